fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter that shares the write port of one `FIFO_memory` instance among `NUM_REQ` producers. Each producer is granted the FIFO for a burst of up to `MAX_BURST` words. The arbiter drives `WR`/`dataIn` directly into the FIFO and honours its `FULL` flag, so no word is ever offered to a full FIFO. It sits between the producer blocks and the FIFO's write side; the read side is untouched.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `MAX_BURST`, 4: maximum words per grant, 1 or more.

Ports:
- `Clk`  in  1: single clock, rising edge.
- `Rst`  in  1: asynchronous, active-high reset.
- `req`  in  NUM_REQ: per-requester "word valid". Bit i high means `reqData` slice i holds a word.
- `reqData`  in  NUM_REQ*DATA_WIDTH: flattened words; slice i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `ack`  out  NUM_REQ: one-hot or zero. Bit i high means the word from requester i is written this cycle.
- `FULL`  in  1: from the FIFO's `FULL`.
- `WR`  out  1: to the FIFO's `WR`.
- `dataIn`  out  DATA_WIDTH: to the FIFO's `dataIn`.
- `grantId`  out  GW=max(1,$clog2(NUM_REQ)): current grantee; valid while `busy`.
- `busy`  out  1: high in state BURST.

## Operation
- Two-state FSM:
  - IDLE: no transfers, `busy`=0.
  - BURST: requester `grantId` owns the FIFO.
- Registered state: `state`, `grantId`, `lastId` (round-robin pointer), `burstCnt` (width $clog2(MAX_BURST+1)).
- Round-robin pick from vector `v` with pointer `p`: choose the first set bit scanning from index p+1 upward, wrapping modulo NUM_REQ. Index p itself is scanned last.
- IDLE: if `|req`, then `grantId` <= pick(req, lastId), `burstCnt` <= 0, go to BURST. Otherwise stay in IDLE.
- BURST, combinational outputs:
  - `ack[grantId]` = `req[grantId] & !FULL`; all other bits are 0.
  - `WR` = `|ack`.
  - `dataIn` = `reqData` slice `grantId`.
- BURST, on each ack: `burstCnt`++.
- Release condition, evaluated each BURST cycle:
  - `req[grantId]`=0, or
  - ack with `burstCnt`==MAX_BURST-1 (that is, the last word of the burst).
- On release:
  - `lastId` <= `grantId`.
  - If `|req`, then `grantId` <= pick(req, grantId), `burstCnt` <= 0, stay in BURST. This is a back-to-back handover with no bubble. The releasing requester has lowest priority and can win only if it is the sole requester.
  - Otherwise go to IDLE.
- FULL during BURST: `ack`=0 and `WR`=0. Grant and `burstCnt` hold. There is no timeout, and no release occurs while `req[grantId]` stays high.
- Outside BURST: `ack`=0, `WR`=0, `dataIn`=0.
- Requesters hold `req` and their data stable until `ack`. Dropping `req` before `ack` abandons the word. The arbiter never writes a word without asserting the matching `ack`.

## Timing
- Reset values: `state`=IDLE, `grantId`=0, `lastId`=NUM_REQ-1 (requester 0 wins first), `burstCnt`=0. Outputs: `ack`=0, `WR`=0, `dataIn`=0, `busy`=0.
- Reset mid-burst: the FSM aborts immediately. The word on the reset edge is not written; the FIFO is reset by the same `Rst`.
- Latency from IDLE: `req` rising at edge n gives a grant at edge n+1, with `ack`/`WR` combinationally in the cycle after edge n+1. From then on, throughput is one word per cycle while not FULL.
- Handover: the last word of burst A and the first word of burst B are in consecutive cycles.
- `FULL` to `WR` path is combinational (same cycle). The FIFO's `FULL` is registered, so there is no loop.

## Structure
- Package `fifo_arb_pkg` holds:
  - state enum {IDLE, BURST};
  - width function `clog2`;
  - reset constants.
- Sub-module `rr_picker`: combinational. Inputs `v[NUM_REQ]` and `p[GW]`. Outputs `found` and `idx[GW]`. It is used once, with p muxed between `lastId` (IDLE) and `grantId` (release).
- Everything else is in `fifo_write_arbiter`.

## Test plan
All tests use NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8.
- Reset, then `req`=4'b0001 with data 8'hA0..A5 over six accepted words. Required response: grant 0, words A0..A3 acked in four consecutive cycles, one re-arbitration handover back to 0 with no bubble, then A4 and A5 written in order.
- `req`=4'b1111 held continuously. Required response: grant order 0,1,2,3,0, with exactly four acks per burst and no idle cycle between bursts.
- Requester 2 sends 2 words then drops `req` while `req`=4'b1010 is also pending. Required response: release after word 2, next grant goes to 3, then to 1.
- FULL forced high for 3 cycles in the middle of burst 1. Required response: `WR`=0 and `ack`=0 for those cycles, `grantId` stays 1, `burstCnt` holds, and the burst completes with 4 words total afterwards.
- `Rst` pulsed mid-burst (grant 2, `burstCnt`=2). Required response: all outputs 0 immediately. After release, `req`=4'b1100 grants 2 first, because `lastId` reset to 3.
- End-to-end with a real `FIFO_memory` (depth 16) and the read side idle. Requesters push 20 words. Required response: exactly 16 acks, FULL=1, no overflow. After 16 reads, the data order matches the ack order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types, width helper and reset constants for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Ceiling log2 usable in parameter expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam arb_state_e STATE_RST = IDLE;
  localparam int GRANT_RST = 0;
  localparam int BURST_CNT_RST = 0;

  function automatic int lastIdRst(input int numReq);
    return numReq - 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first set bit of v scanning upward from p+1, wrapping, p last.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] v,
  input  logic [GW-1:0]      p,
  output logic               found,
  output logic [GW-1:0]      idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && v[(int'(p) + k) % NUM_REQ]) begin
        found = 1'b1;
        idx   = GW'((int'(p) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                                         Clk,
  input  logic                                         Rst,
  input  logic [NUM_REQ-1:0]                           req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                reqData,
  output logic [NUM_REQ-1:0]                           ack,
  input  logic                                         FULL,
  output logic                                         WR,
  output logic [DATA_WIDTH-1:0]                        dataIn,
  output logic [((clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1)-1:0] grantId,
  output logic                                         busy
);

  localparam int GW = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1;
  localparam int BW = clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grantId_q, grantId_d;
  logic [GW-1:0] lastId_q, lastId_d;
  logic [BW-1:0] burstCnt_q, burstCnt_d;

  logic          reqGrant;
  logic          wrAny;
  logic          releaseGrant;
  logic [GW-1:0] pickPtr;
  logic          pickFound;
  logic [GW-1:0] pickIdx;

  // One picker serves both the initial grant and the back-to-back handover.
  assign pickPtr = (state_q == IDLE) ? lastId_q : grantId_q;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .GW     (GW)
  ) u_picker (
    .v    (req),
    .p    (pickPtr),
    .found(pickFound),
    .idx  (pickIdx)
  );

  always_comb begin
    reqGrant = 1'b0;
    ack      = '0;
    dataIn   = '0;
    if (state_q == BURST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grantId_q == GW'(i)) begin
          reqGrant = req[i];
          ack[i]   = req[i] & ~FULL;
          dataIn   = reqData[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign wrAny        = |ack;
  assign WR           = wrAny;
  assign busy         = (state_q == BURST);
  assign grantId      = grantId_q;
  assign releaseGrant = !reqGrant || (wrAny && (burstCnt_q == BW'(MAX_BURST - 1)));

  always_comb begin
    state_d    = state_q;
    grantId_d  = grantId_q;
    lastId_d   = lastId_q;
    burstCnt_d = burstCnt_q;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          grantId_d  = pickIdx;
          burstCnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (wrAny) burstCnt_d = burstCnt_q + BW'(1);
        // The releasing grantee is scanned last, so it wins only when alone.
        if (releaseGrant) begin
          lastId_d = grantId_q;
          if (pickFound) begin
            grantId_d  = pickIdx;
            burstCnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= STATE_RST;
      grantId_q  <= GW'(GRANT_RST);
      lastId_q   <= GW'(lastIdRst(NUM_REQ));
      burstCnt_q <= BW'(BURST_CNT_RST);
    end else begin
      state_q    <= state_d;
      grantId_q  <= grantId_d;
      lastId_q   <= lastId_d;
      burstCnt_q <= burstCnt_d;
    end
  end

endmodule
